alu_flag_unit: RTL and testbench
================================

Name: alu_flag_unit

Overview:
Sequential consumer of the ALU's flag and extended-result outputs. It latches carry/sign/zero into a 3-bit condition code register (CCR) and latches the upper 32 bits of a MUL into a HI register. It provides a small CCR save/restore stack for interrupt entry and return, and evaluates branch conditions for the fetch/branch logic. It sits between the execute stage (ALU) and the branch unit and interrupt controller.

Parameters:
STACK_DEPTH, 2, number of CCR entries the save/restore stack holds (1..8).
OP_MUL, 11, opSel encoding of multiply; selects the HI capture.

Ports:
clk  input  1  clock, all state updates on rising edge.
rstN  input  1  asynchronous active-low reset.
carryFlag  input  1  ALU carry/borrow flag.
signFlag  input  1  ALU sign flag (result bit 31).
zeroFlag  input  1  ALU zero flag.
resultExt  input  32  ALU upper product word; valid only for MUL.
opSel  input  4  ALU opcode of the instruction currently executing.
flagWrEn  input  1  instruction in execute commits its flags/HI this cycle.
setC  input  1  force C=1 (SETC instruction).
clrC  input  1  force C=0 (CLRC instruction).
push  input  1  save CCR on the stack (interrupt entry).
pop  input  1  restore CCR from the stack (RTI).
condSel  input  3  branch condition: 0 always, 1 Z, 2 !Z, 3 C, 4 !C, 5 N, 6 !N, 7 never.
ccr  output  3  {C,N,Z}, registered.
hi  output  32  registered upper product.
condTrue  output  1  selected condition evaluated on ccr.
stackEmpty  output  1  stack holds zero entries (combinational from the count).
stackFull  output  1  stack holds STACK_DEPTH entries.
stackErr  output  1  registered one-cycle pulse on overflow/underflow.

Behaviour:
- Reset (rstN=0, asynchronous): ccr=3'b000, hi=0, stack count=0 (stackEmpty=1, stackFull=0), stackErr=0, all stack entries cleared.
- Flag commit when flagWrEn=1:
  - opSel 0..10 (logic, shift, add, sub): Z<=zeroFlag, N<=signFlag, C<=carryFlag.
  - opSel 11, 12 (MUL, DIV): Z and N updated; C held.
  - opSel 13..15 (PASS, PASSB, undefined): no flag update.
- HI: hi<=resultExt when flagWrEn=1 and opSel==OP_MUL; otherwise held.
- CCR next-value priority, highest first:
  1. A legal pop: ccr<=top entry. setC, clrC and the flag commit are ignored for ccr, but the HI capture still occurs.
  2. setC/clrC: C<=1 or C<=0. If both are set, C is held. Z and N still take the flag commit if it applies.
  3. Flag commit.
- Push: the entry written is the ccr value before this edge. Any ccr update in the same cycle still takes effect. A push is legal when count<STACK_DEPTH; count increments.
- Pop: legal when count>0; count decrements.
- Push when full: the stack and count are unchanged and stackErr=1 for one cycle.
- Pop when empty: the stack and count are unchanged, ccr follows the priorities 2 and 3, and stackErr=1 for one cycle.
- push and pop in the same cycle: both are ignored, count is unchanged, stackErr=1 for one cycle. ccr follows priorities 2 and 3.
- Latency: a flag commit in cycle n is visible on ccr and condTrue in cycle n+1 (the default build).
- condTrue is combinational from the registered ccr and condSel.
- The stack is LIFO, with the count ranging 0..STACK_DEPTH and no wrap-around.

Optional Feature:
ALU_FLAG_FWD_EN
- Defined: condTrue is evaluated on the next-ccr value (the output of the priority logic above), so a branch can use flags committed in the same cycle with zero latency.
- Undefined: condTrue uses the registered ccr only, giving one cycle of latency.
- ccr, hi and stack behaviour are identical in both builds.

Test Plan:
- Reset, then flagWrEn=1 with opSel=9 (ADD), carryFlag=1, signFlag=0, zeroFlag=1 -> next cycle ccr=3'b101. With condSel=1, condTrue=1; with condSel=4, condTrue=0.
- ccr=3'b101, then flagWrEn=1 with opSel=11, carry=0, sign=1, zero=0, resultExt=32'hDEAD_BEEF -> ccr=3'b110 and hi=32'hDEAD_BEEF. Then opSel=13 with zeroFlag=1 -> ccr and hi unchanged.
- Push with ccr=3'b010, then clrC and flag writes alter ccr, then pop -> ccr=3'b010 and stackEmpty=1. A further pop -> stackErr pulses for one cycle and ccr is unchanged.
- With STACK_DEPTH=2: three pushes -> stackFull=1 after the second push. The third push pulses stackErr and count stays at 2. Two pops return the entries in LIFO order.
- push=1 and pop=1 together with count=1 -> count stays 1 and stackErr pulses. setC=1 and clrC=1 in the same cycle -> C is unchanged.
- rstN driven low mid-cycle with count=2 and ccr=3'b111 -> ccr=0, hi=0 and stackEmpty=1 immediately, without waiting for a clock edge. With ALU_FLAG_FWD_EN, a flag write with zeroFlag=1 and condSel=1 -> condTrue=1 in the same cycle.

Source files
------------

// File: rtl/alu_flag_unit.sv
// alu_flag_unit: condition-code register, HI capture, CCR save/restore stack
// and branch-condition evaluation behind the ALU.
//
// Build option: ALU_FLAG_FWD_EN
//   defined   -> condTrue is evaluated on the next-ccr value (zero latency)
//   undefined -> condTrue is evaluated on the registered ccr (one cycle)
//
// ccr layout is {C, N, Z}.
// The block has no FSM and no valid/ready handshakes. push, pop and
// flagWrEn are single-cycle strobes sampled on the rising clock edge.
module alu_flag_unit #(
    parameter int         STACK_DEPTH = 2,
    parameter logic [3:0] OP_MUL      = 4'd11
) (
    input  logic        clk,
    input  logic        rstN,
    input  logic        carryFlag,
    input  logic        signFlag,
    input  logic        zeroFlag,
    input  logic [31:0] resultExt,
    input  logic [3:0]  opSel,
    input  logic        flagWrEn,
    input  logic        setC,
    input  logic        clrC,
    input  logic        push,
    input  logic        pop,
    input  logic [2:0]  condSel,
    output logic [2:0]  ccr,
    output logic [31:0] hi,
    output logic        condTrue,
    output logic        stackEmpty,
    output logic        stackFull,
    output logic        stackErr
);

    // Count spans 0..STACK_DEPTH; entries are addressed with AW bits.
    localparam int CW = $clog2(STACK_DEPTH + 1);
    localparam int AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [2:0]    stackMem [STACK_DEPTH];
    logic [CW-1:0] count;
    logic [CW-1:0] countM1;
    logic [2:0]    ccrNext;
    logic [2:0]    evalCcr;
    logic          pushReq;
    logic          popReq;
    logic          pushOk;
    logic          popOk;
    logic          errNext;
    logic          commitAll;
    logic          commitZn;

    assign stackEmpty = (count == '0);
    assign stackFull  = (count == CW'(STACK_DEPTH));
    assign countM1    = count - CW'(1);

    // A simultaneous push and pop cancels both and is reported as an error.
    assign pushReq = push & ~pop;
    assign popReq  = pop & ~push;
    assign pushOk  = pushReq & ~stackFull;
    assign popOk   = popReq & ~stackEmpty;
    assign errNext = (push & pop) | (pushReq & stackFull) | (popReq & stackEmpty);

    // Opcodes 0..10 write all flags, MUL/DIV (11, 12) keep C, 13..15 write nothing.
    assign commitAll = flagWrEn && (opSel <= 4'd10);
    assign commitZn  = flagWrEn && (opSel <= 4'd12);

    // Next ccr: a legal pop wins outright, then setC/clrC on C, then the flag commit.
    always_comb begin
        ccrNext = ccr;
        if (popOk) begin
            ccrNext = stackMem[countM1[AW-1:0]];
        end else begin
            if (commitZn) begin
                ccrNext[1] = signFlag;
                ccrNext[0] = zeroFlag;
            end
            if (setC || clrC) begin
                // Both asserted together leaves C as it was.
                if (setC ^ clrC) begin
                    ccrNext[2] = setC;
                end
            end else if (commitAll) begin
                ccrNext[2] = carryFlag;
            end
        end
    end

`ifdef ALU_FLAG_FWD_EN
    assign evalCcr = ccrNext;
`else
    assign evalCcr = ccr;
`endif

    // Branch condition decode on the selected ccr view.
    always_comb begin
        condTrue = 1'b0;
        case (condSel)
            3'd0: condTrue = 1'b1;
            3'd1: condTrue = evalCcr[0];
            3'd2: condTrue = ~evalCcr[0];
            3'd3: condTrue = evalCcr[2];
            3'd4: condTrue = ~evalCcr[2];
            3'd5: condTrue = evalCcr[1];
            3'd6: condTrue = ~evalCcr[1];
            default: condTrue = 1'b0;
        endcase
    end

    // ccr, HI and the error pulse registers.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            ccr      <= 3'b000;
            hi       <= 32'd0;
            stackErr <= 1'b0;
        end else begin
            ccr      <= ccrNext;
            stackErr <= errNext;
            if (flagWrEn && (opSel == OP_MUL)) begin
                hi <= resultExt;
            end
        end
    end

    // LIFO storage: push saves the pre-edge ccr, pop only moves the count.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            count <= '0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stackMem[i] <= 3'b000;
            end
        end else if (pushOk) begin
            stackMem[count[AW-1:0]] <= ccr;
            count                   <= count + CW'(1);
        end else if (popOk) begin
            count <= countM1;
        end
    end

endmodule

// File: tb/tb_alu_flag_unit.sv
// Directed bench for alu_flag_unit (STACK_DEPTH=2, default build unless
// ALU_FLAG_FWD_EN is defined for both files).
module tb_alu_flag_unit;

    logic        clk;
    logic        rstN;
    logic        carryFlag;
    logic        signFlag;
    logic        zeroFlag;
    logic [31:0] resultExt;
    logic [3:0]  opSel;
    logic        flagWrEn;
    logic        setC;
    logic        clrC;
    logic        push;
    logic        pop;
    logic [2:0]  condSel;
    logic [2:0]  ccr;
    logic [31:0] hi;
    logic        condTrue;
    logic        stackEmpty;
    logic        stackFull;
    logic        stackErr;

    int nCmp = 0;
    int nErr = 0;
    logic [2:0] exp_q[$];
    logic [2:0] expV;

    alu_flag_unit #(.STACK_DEPTH(2), .OP_MUL(4'd11)) dut (
        .clk(clk), .rstN(rstN), .carryFlag(carryFlag), .signFlag(signFlag),
        .zeroFlag(zeroFlag), .resultExt(resultExt), .opSel(opSel),
        .flagWrEn(flagWrEn), .setC(setC), .clrC(clrC), .push(push), .pop(pop),
        .condSel(condSel), .ccr(ccr), .hi(hi), .condTrue(condTrue),
        .stackEmpty(stackEmpty), .stackFull(stackFull), .stackErr(stackErr)
    );

    // Clock and watchdog.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    // Driver tasks.
    task automatic idleInputs();
        carryFlag = 0; signFlag = 0; zeroFlag = 0; resultExt = 32'd0;
        opSel = 4'd0; flagWrEn = 0; setC = 0; clrC = 0; push = 0; pop = 0;
        condSel = 3'd0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idleInputs();
        #1;
    endtask

    task automatic flagWrite(input logic [3:0] op, input logic c, input logic s,
                             input logic z, input logic [31:0] ext);
        flagWrEn = 1; opSel = op; carryFlag = c; signFlag = s; zeroFlag = z;
        resultExt = ext;
    endtask

    task automatic test_reset();
        nCmp++; if (ccr !== 3'b000) begin nErr++; $display("FAIL reset_ccr: got %b want %b", ccr, 3'b000); end
        nCmp++; if (hi !== 32'd0) begin nErr++; $display("FAIL reset_hi: got %h want %h", hi, 32'd0); end
        nCmp++; if (stackEmpty !== 1'b1) begin nErr++; $display("FAIL reset_empty: got %b want 1", stackEmpty); end
        nCmp++; if (stackFull !== 1'b0) begin nErr++; $display("FAIL reset_full: got %b want 0", stackFull); end
        nCmp++; if (stackErr !== 1'b0) begin nErr++; $display("FAIL reset_err: got %b want 0", stackErr); end
    endtask

    task automatic test_add_flags();
        flagWrite(4'd9, 1, 0, 1, 32'h0);
        step();
        nCmp++; if (ccr !== 3'b101) begin nErr++; $display("FAIL add_ccr: got %b want %b", ccr, 3'b101); end
        condSel = 3'd1; #1;
        nCmp++; if (condTrue !== 1'b1) begin nErr++; $display("FAIL cond_z: got %b want 1", condTrue); end
        condSel = 3'd4; #1;
        nCmp++; if (condTrue !== 1'b0) begin nErr++; $display("FAIL cond_nc: got %b want 0", condTrue); end
        condSel = 3'd6; #1;
        nCmp++; if (condTrue !== 1'b1) begin nErr++; $display("FAIL cond_nn: got %b want 1", condTrue); end
        condSel = 3'd7; #1;
        nCmp++; if (condTrue !== 1'b0) begin nErr++; $display("FAIL cond_never: got %b want 0", condTrue); end
    endtask

    task automatic test_mul_hi();
        flagWrite(4'd11, 0, 1, 0, 32'hDEAD_BEEF);
        step();
        nCmp++; if (ccr !== 3'b110) begin nErr++; $display("FAIL mul_ccr: got %b want %b", ccr, 3'b110); end
        nCmp++; if (hi !== 32'hDEAD_BEEF) begin nErr++; $display("FAIL mul_hi: got %h want %h", hi, 32'hDEAD_BEEF); end
        flagWrite(4'd13, 0, 0, 1, 32'h1111_2222);
        step();
        nCmp++; if (ccr !== 3'b110) begin nErr++; $display("FAIL pass_ccr: got %b want %b", ccr, 3'b110); end
        nCmp++; if (hi !== 32'hDEAD_BEEF) begin nErr++; $display("FAIL pass_hi: got %h want %h", hi, 32'hDEAD_BEEF); end
        // SUB must not capture HI.
        flagWrite(4'd10, 1, 1, 0, 32'h3333_4444);
        step();
        nCmp++; if (ccr !== 3'b110) begin nErr++; $display("FAIL sub_ccr: got %b want %b", ccr, 3'b110); end
        nCmp++; if (hi !== 32'hDEAD_BEEF) begin nErr++; $display("FAIL sub_hi: got %h want %h", hi, 32'hDEAD_BEEF); end
    endtask

    task automatic test_push_pop();
        clrC = 1;
        step();
        nCmp++; if (ccr !== 3'b010) begin nErr++; $display("FAIL clrc_ccr: got %b want %b", ccr, 3'b010); end
        push = 1;
        step();
        nCmp++; if (stackEmpty !== 1'b0) begin nErr++; $display("FAIL push_empty: got %b want 0", stackEmpty); end
        flagWrite(4'd9, 1, 0, 1, 32'h0);
        clrC = 1;
        step();
        nCmp++; if (ccr !== 3'b001) begin nErr++; $display("FAIL clrc_prio: got %b want %b", ccr, 3'b001); end
        // Legal pop overrides setC and the commit; HI capture still happens.
        pop = 1; setC = 1;
        flagWrite(4'd11, 1, 1, 1, 32'h1234_5678);
        step();
        nCmp++; if (ccr !== 3'b010) begin nErr++; $display("FAIL pop_ccr: got %b want %b", ccr, 3'b010); end
        nCmp++; if (hi !== 32'h1234_5678) begin nErr++; $display("FAIL pop_hi: got %h want %h", hi, 32'h1234_5678); end
        nCmp++; if (stackEmpty !== 1'b1) begin nErr++; $display("FAIL pop_empty: got %b want 1", stackEmpty); end
        nCmp++; if (stackErr !== 1'b0) begin nErr++; $display("FAIL pop_noerr: got %b want 0", stackErr); end
        pop = 1;
        step();
        nCmp++; if (stackErr !== 1'b1) begin nErr++; $display("FAIL underflow_err: got %b want 1", stackErr); end
        nCmp++; if (ccr !== 3'b010) begin nErr++; $display("FAIL underflow_ccr: got %b want %b", ccr, 3'b010); end
        step();
        nCmp++; if (stackErr !== 1'b0) begin nErr++; $display("FAIL err_pulse: got %b want 0", stackErr); end
    endtask

    task automatic test_overflow();
        push = 1; setC = 1; exp_q.push_back(3'b010);
        step();
        push = 1; flagWrite(4'd0, 0, 0, 1, 32'h0); exp_q.push_back(3'b110);
        step();
        nCmp++; if (stackFull !== 1'b1) begin nErr++; $display("FAIL full_flag: got %b want 1", stackFull); end
        nCmp++; if (ccr !== 3'b001) begin nErr++; $display("FAIL push2_ccr: got %b want %b", ccr, 3'b001); end
        push = 1;
        step();
        nCmp++; if (stackErr !== 1'b1) begin nErr++; $display("FAIL overflow_err: got %b want 1", stackErr); end
        nCmp++; if (stackFull !== 1'b1) begin nErr++; $display("FAIL overflow_full: got %b want 1", stackFull); end
        for (int i = 0; i < 2; i++) begin
            pop = 1;
            step();
            expV = exp_q.pop_back();
            nCmp++; if (ccr !== expV) begin nErr++; $display("FAIL lifo_pop%0d: got %b want %b", i, ccr, expV); end
        end
        nCmp++; if (stackEmpty !== 1'b1) begin nErr++; $display("FAIL lifo_empty: got %b want 1", stackEmpty); end
    endtask

    task automatic test_push_and_pop();
        push = 1;
        step();
        push = 1; pop = 1; setC = 1; clrC = 1;
        flagWrite(4'd9, 1, 1, 1, 32'h0);
        step();
        nCmp++; if (ccr !== 3'b011) begin nErr++; $display("FAIL both_ccr: got %b want %b", ccr, 3'b011); end
        nCmp++; if (stackErr !== 1'b1) begin nErr++; $display("FAIL both_err: got %b want 1", stackErr); end
        nCmp++; if (stackEmpty !== 1'b0 || stackFull !== 1'b0) begin nErr++; $display("FAIL both_count: got empty=%b full=%b want empty=0 full=0", stackEmpty, stackFull); end
        pop = 1;
        step();
        nCmp++; if (ccr !== 3'b010) begin nErr++; $display("FAIL both_pop: got %b want %b", ccr, 3'b010); end
        nCmp++; if (stackEmpty !== 1'b1) begin nErr++; $display("FAIL both_empty: got %b want 1", stackEmpty); end
    endtask

    task automatic test_async_reset();
        push = 1;
        step();
        push = 1; flagWrite(4'd9, 1, 1, 1, 32'h0);
        step();
        nCmp++; if (ccr !== 3'b111 || stackFull !== 1'b1) begin nErr++; $display("FAIL prereset: got ccr=%b full=%b want ccr=111 full=1", ccr, stackFull); end
        #1;
        rstN = 0;
        #1;
        nCmp++; if (ccr !== 3'b000) begin nErr++; $display("FAIL async_ccr: got %b want %b", ccr, 3'b000); end
        nCmp++; if (hi !== 32'd0) begin nErr++; $display("FAIL async_hi: got %h want %h", hi, 32'd0); end
        nCmp++; if (stackEmpty !== 1'b1) begin nErr++; $display("FAIL async_empty: got %b want 1", stackEmpty); end
        @(negedge clk);
        rstN = 1;
        #1;
    endtask

    task automatic test_cond_latency();
        flagWrite(4'd9, 0, 0, 1, 32'h0);
        condSel = 3'd1;
        #1;
`ifdef ALU_FLAG_FWD_EN
        nCmp++; if (condTrue !== 1'b1) begin nErr++; $display("FAIL fwd_cond: got %b want 1", condTrue); end
`else
        nCmp++; if (condTrue !== 1'b0) begin nErr++; $display("FAIL nofwd_cond: got %b want 0", condTrue); end
`endif
        @(posedge clk);
        #1;
        nCmp++; if (condTrue !== 1'b1) begin nErr++; $display("FAIL cond_after: got %b want 1", condTrue); end
        idleInputs();
        #1;
    endtask

    initial begin
        rstN = 0;
        idleInputs();
        #12;
        test_reset();
        #5;
        rstN = 1;
        test_add_flags();
        test_mul_hi();
        test_push_pop();
        test_overflow();
        test_push_and_pop();
        test_async_reset();
        test_cond_latency();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
